// File: rtl/vx_flush_sequencer.sv
// Cache flush/invalidate sequencer: walks every (line, way) index and broadcasts
// one flush request per index to all banks, each bank handshaking independently.
module vx_flush_sequencer #(
   parameter int NUM_LINES     = 64,
   parameter int NUM_WAYS      = 1,
   parameter int NUM_BANKS     = 1,
   parameter int INIT_ON_RESET = 1,
   parameter int LINE_BITS     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
   parameter int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_req_valid,
   output logic                 flush_req_ready,
   output logic [NUM_BANKS-1:0] flush_valid,
   input  logic [NUM_BANKS-1:0] flush_ready,
   output logic [LINE_BITS-1:0] flush_line,
   output logic [WAY_BITS-1:0]  flush_way,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

   localparam logic [LINE_BITS-1:0] LINE_MAX = LINE_BITS'(NUM_LINES - 1);
   localparam logic [WAY_BITS-1:0]  WAY_MAX  = WAY_BITS'(NUM_WAYS - 1);

   state_t               state, state_n;
   logic [LINE_BITS-1:0] line_ctr, line_n;
   logic [WAY_BITS-1:0]  way_ctr, way_n;
   logic [NUM_BANKS-1:0] sent, sent_n, fire;
   logic                 line_last, way_last;

   assign line_last = (line_ctr == LINE_MAX);
   assign way_last  = (way_ctr == WAY_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= (INIT_ON_RESET != 0) ? FLUSH : IDLE;
         line_ctr <= '0;
         way_ctr  <= '0;
         sent     <= '0;
      end else begin
         state    <= state_n;
         line_ctr <= line_n;
         way_ctr  <= way_n;
         sent     <= sent_n;
      end
   end

   always_comb begin
      state_n         = state;
      line_n          = line_ctr;
      way_n           = way_ctr;
      sent_n          = sent;
      fire            = '0;
      flush_req_ready = 1'b0;
      flush_valid     = '0;
      done            = 1'b0;
      case (state)
         IDLE: begin
            flush_req_ready = 1'b1;
            if (flush_req_valid) begin
               state_n = FLUSH;
               line_n  = '0;
               way_n   = '0;
               sent_n  = '0;
            end
         end
         FLUSH: begin
            // valid depends only on sent, never on flush_ready
            flush_valid = ~sent;
            fire        = ~sent & flush_ready;
            sent_n      = sent | fire;
            if (&sent_n) begin
               sent_n = '0;
               way_n  = way_last ? '0 : way_ctr + WAY_BITS'(1);
               if (way_last) line_n = line_last ? '0 : line_ctr + LINE_BITS'(1);
               if (way_last && line_last) state_n = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (reset) begin
         flush_req_ready = 1'b0;
         flush_valid     = '0;
         done            = 1'b0;
      end
   end

   assign busy       = (state != IDLE);
   assign flush_line = reset ? '0 : line_ctr;
   assign flush_way  = reset ? '0 : way_ctr;

endmodule

// File: tb/tb_vx_flush_sequencer.sv
// Bench for vx_flush_sequencer: three configurations checked every cycle against
// an index-position model, plus directed walks with literal expectations.
module tb_vx_flush_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]      rst, req_v;
   logic [2:0][2:0] rdy;
   logic [2:0]      rr, bz, dn, fw;
   logic [2:0][2:0] fv;
   logic [2:0][1:0] fl;
   logic [1:0]      fv0, fv1, fl0, fl1;
   logic [2:0]      fv2;
   logic            fl2;

   assign fv[0] = {1'b0, fv0};
   assign fv[1] = {1'b0, fv1};
   assign fv[2] = fv2;
   assign fl[0] = fl0;
   assign fl[1] = fl1;
   assign fl[2] = {1'b0, fl2};

   vx_flush_sequencer #(.NUM_LINES(4), .NUM_WAYS(2), .NUM_BANKS(2), .INIT_ON_RESET(1)) u0 (
      .clk(clk), .reset(rst[0]), .flush_req_valid(req_v[0]), .flush_req_ready(rr[0]),
      .flush_valid(fv0), .flush_ready(rdy[0][1:0]), .flush_line(fl0), .flush_way(fw[0]),
      .busy(bz[0]), .done(dn[0]));

   vx_flush_sequencer #(.NUM_LINES(4), .NUM_WAYS(2), .NUM_BANKS(2), .INIT_ON_RESET(0)) u1 (
      .clk(clk), .reset(rst[1]), .flush_req_valid(req_v[1]), .flush_req_ready(rr[1]),
      .flush_valid(fv1), .flush_ready(rdy[1][1:0]), .flush_line(fl1), .flush_way(fw[1]),
      .busy(bz[1]), .done(dn[1]));

   vx_flush_sequencer #(.NUM_LINES(1), .NUM_WAYS(1), .NUM_BANKS(3), .INIT_ON_RESET(1)) u2 (
      .clk(clk), .reset(rst[2]), .flush_req_valid(req_v[2]), .flush_req_ready(rr[2]),
      .flush_valid(fv2), .flush_ready(rdy[2]), .flush_line(fl2), .flush_way(fw[2]),
      .busy(bz[2]), .done(dn[2]));

   int tests = 0;
   int fails = 0;

   // Model: pos = -1 idle, 0..N-1 index being flushed, N = done cycle.
   int         pos[3] = '{-1, -1, -1};
   logic [2:0] sent_m[3] = '{3'b0, 3'b0, 3'b0};

   function automatic int nline(int d); return (d == 2) ? 1 : 4; endfunction
   function automatic int nway(int d);  return (d == 2) ? 1 : 2; endfunction
   function automatic logic [2:0] bmask(int d); return (d == 2) ? 3'b111 : 3'b011; endfunction
   function automatic int ninit(int d); return (d == 1) ? 0 : 1; endfunction

   function automatic logic [2:0] mfv(int d);
      if (pos[d] >= 0 && pos[d] < nline(d) * nway(d)) return ~sent_m[d] & bmask(d);
      return 3'b000;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   task automatic step(input int d);
      int         n;
      logic [2:0] s;
      n = nline(d) * nway(d);
      if (rst[d]) begin
         pos[d]    = (ninit(d) != 0) ? 0 : -1;
         sent_m[d] = 3'b000;
      end else if (pos[d] < 0) begin
         if (req_v[d]) begin pos[d] = 0; sent_m[d] = 3'b000; end
      end else if (pos[d] >= n) begin
         pos[d] = -1;
      end else begin
         s = sent_m[d] | (mfv(d) & rdy[d]);
         if ((s & bmask(d)) == bmask(d)) begin
            sent_m[d] = 3'b000;
            pos[d]    = pos[d] + 1;
         end else sent_m[d] = s;
      end
   endtask

   task automatic compare(input int d);
      int n, ln, wy;
      n  = nline(d) * nway(d);
      ln = (pos[d] >= 0 && pos[d] < n) ? pos[d] / nway(d) : 0;
      wy = (pos[d] >= 0 && pos[d] < n) ? pos[d] % nway(d) : 0;
      if (rst[d]) begin
         chk("rst_valid", d, fv[d], 0);
         chk("rst_done", d, dn[d], 0);
         chk("rst_req_ready", d, rr[d], 0);
         chk("rst_index", d, {fl[d], fw[d]}, 0);
      end else begin
         chk("m_valid", d, fv[d], mfv(d));
         chk("m_line", d, fl[d], ln);
         chk("m_way", d, fw[d], wy);
         chk("m_done", d, dn[d], (pos[d] == n) ? 1 : 0);
         chk("m_busy", d, bz[d], (pos[d] != -1) ? 1 : 0);
         chk("m_req_ready", d, rr[d], (pos[d] == -1) ? 1 : 0);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) compare(d);
         @(posedge clk);
         for (int d = 0; d < 3; d++) step(d);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      rst = 3'b111; req_v = 3'b000;
      rdy[0] = 3'b011; rdy[1] = 3'b011; rdy[2] = 3'b011;
      repeat (3) tick;
      rst = 3'b000;

      // Full walk out of reset; u1 starts on a one-cycle request; u2 bank2 late.
      for (int k = 0; k < 8; k++) begin
         if (k == 0) req_v[1] = 1'b1;
         if (k == 1) req_v[1] = 1'b0;
         if (k == 2) rdy[2] = 3'b111;
         @(negedge clk);
         chk("a_valid", 0, fv[0], 3);
         chk("a_index", 0, {fl[0], fw[0]}, k);
         if (k == 0) begin
            chk("a_valid_1x1", 2, fv[2], 3'b111);
            chk("a_idle_busy", 1, bz[1], 0);
            chk("a_idle_ready", 1, rr[1], 1);
         end
         if (k == 1 || k == 2) chk("a_valid_1x1_hold", 2, fv[2], 3'b100);
         if (k == 1) begin
            chk("a_req_busy", 1, bz[1], 1);
            chk("a_req_index", 1, {fl[1], fw[1]}, 0);
         end
         if (k == 3) chk("a_done_1x1", 2, dn[2], 1);
         if (k == 4) chk("a_idle_1x1", 2, rr[2], 1);
         tick;
      end
      @(negedge clk);
      chk("a_done", 0, dn[0], 1);
      chk("a_done_busy", 0, bz[0], 1);
      tick;
      @(negedge clk);
      chk("a_after_busy", 0, bz[0], 0);
      chk("a_after_ready", 0, rr[0], 1);
      tick;

      // Backpressure at (1,0) and a request held during the walk.
      req_v[0] = 1'b1;
      tick;
      req_v[0] = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (c == 2) begin rdy[0] = 3'b001; req_v[0] = 1'b1; end
         if (c == 5) rdy[0] = 3'b011;
         if (c == 13) req_v[0] = 1'b0;
         @(negedge clk);
         if (c == 3) begin
            chk("b_valid_bp", 0, fv[0], 2'b10);
            chk("b_index_bp", 0, {fl[0], fw[0]}, 2);
         end
         if (c == 5) chk("b_hold", 0, {fl[0], fw[0]}, 2);
         if (c == 6) chk("b_advance", 0, {fl[0], fw[0]}, 3);
         if (c >= 2 && c <= 11) chk("b_req_blocked", 0, rr[0], 0);
         if (c == 11) chk("b_done", 0, dn[0], 1);
         if (c == 12) chk("b_req_accept", 0, rr[0], 1);
         if (c == 13) begin
            chk("b_restart_busy", 0, bz[0], 1);
            chk("b_restart_index", 0, {fl[0], fw[0]}, 0);
         end
         tick;
      end

      // Reset mid-walk at (2,1).
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({fl[0], fw[0]} == 3'd5) begin found = 1'b1; break; end
      end
      chk("c_reach_2_1", 0, found, 1);
      #2 rst[0] = 1'b1;
      @(negedge clk);
      chk("c_rst_valid", 0, fv[0], 0);
      chk("c_rst_done", 0, dn[0], 0);
      @(posedge clk);
      #1 rst[0] = 1'b0;
      @(negedge clk);
      chk("c_restart_valid", 0, fv[0], 3);
      chk("c_restart_index", 0, {fl[0], fw[0]}, 0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dn[0]) begin found = 1'b1; break; end
      end
      chk("c_walk_done", 0, found, 1);
      tick;

      // Randomized traffic on all three configurations.
      for (int i = 0; i < 4000; i++) begin
         for (int d = 0; d < 3; d++) begin
            rdy[d]   = 3'($urandom_range(0, 7));
            req_v[d] = ($urandom_range(0, 3) == 0);
            rst[d]   = ($urandom_range(0, 99) == 0);
         end
         tick;
      end
      rst = 3'b000;
      tick;
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
